// File: rtl/ps2_pkg.sv
// ps2_pkg -- constants and types shared by the PS/2 receive path and the
// downstream key decoder.
//   PS2_BRK        : break (key release) prefix code
//   PS2_EXT        : extended-key prefix code
//   ps2_state_e    : receiver FSM state encoding
//   odd_parity_ok  : checks odd parity over 8 data bits plus parity bit
package ps2_pkg;

  localparam logic [7:0] PS2_BRK = 8'hF0;
  localparam logic [7:0] PS2_EXT = 8'hE0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DPS  = 2'd1,
    ST_LOAD = 2'd2
  } ps2_state_e;

  // PS/2 uses odd parity: data bits plus parity bit must hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [8:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/ps2_filter.sv
// ps2_filter -- conditions the raw PS/2 pins for the receiver.
//   clk       in  : system clock
//   reset     in  : asynchronous active-low reset
//   ps2c      in  : raw PS/2 clock pin (asynchronous)
//   ps2d      in  : raw PS/2 data pin (asynchronous)
//   ps2d_sync out : 2-flop synchronized data
//   fall_edge out : one-cycle pulse when the filtered PS/2 clock falls
module ps2_filter
  import ps2_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic ps2c,
  input  logic ps2d,
  output logic ps2d_sync,
  output logic fall_edge
);

  logic       ps2c_meta_r;
  logic       ps2c_sync_r;
  logic       ps2d_meta_r;
  logic       ps2d_sync_r;
  logic [7:0] filt_sh_r;
  logic       filt_r;
  logic       fall_edge_r;
  logic [7:0] filt_sh_next_s;
  logic       filt_next_s;

  // Filter decision: change level only once eight consecutive samples agree.
  // Deciding on the next shift value keeps the all-zero reset contents of the
  // shift register from ever producing a spurious low level.
  always_comb begin
    filt_sh_next_s = {ps2c_sync_r, filt_sh_r[7:1]};
    filt_next_s    = filt_r;
    if (filt_sh_next_s == 8'hFF) begin
      filt_next_s = 1'b1;
    end else if (filt_sh_next_s == 8'h00) begin
      filt_next_s = 1'b0;
    end else begin
      filt_next_s = filt_r;
    end
  end

  // Synchronizers, glitch filter and falling-edge pulse register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ps2c_meta_r <= 1'b1;
      ps2c_sync_r <= 1'b1;
      ps2d_meta_r <= 1'b1;
      ps2d_sync_r <= 1'b1;
      filt_sh_r   <= 8'h00;
      filt_r      <= 1'b1;
      fall_edge_r <= 1'b0;
    end else begin
      ps2c_meta_r <= ps2c;
      ps2c_sync_r <= ps2c_meta_r;
      ps2d_meta_r <= ps2d;
      ps2d_sync_r <= ps2d_meta_r;
      filt_sh_r   <= filt_sh_next_s;
      filt_r      <= filt_next_s;
      fall_edge_r <= filt_r & ~filt_next_s;
    end
  end

  assign ps2d_sync = ps2d_sync_r;
  assign fall_edge = fall_edge_r;

endmodule

// File: rtl/ps2_rx_flag.sv
// ps2_rx_flag -- PS/2 keyboard frame receiver with break-code tracking.
//   clk          in  : system clock
//   reset        in  : asynchronous active-low reset
//   ps2c, ps2d   in  : raw PS/2 clock / data pins
//   rx_en        in  : enables reception of a new frame (looked at in IDLE only)
//   dout         out : last valid scan code (F0 prefixes are not stored)
//   rx_done_tick out : one-cycle pulse when dout is updated
//   flag         out : with rx_done_tick, marks a code that followed an F0 prefix
//   err_tick     out : one-cycle pulse on parity, stop-bit or timeout error
module ps2_rx_flag
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2c,
  input  logic       ps2d,
  input  logic       rx_en,
  output logic [7:0] dout,
  output logic       rx_done_tick,
  output logic       flag,
  output logic       err_tick
);

  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic ps2d_sync_s;
  logic fall_edge_s;

  ps2_state_e  state_r,  state_next_s;
  logic [3:0]  cnt_r,    cnt_next_s;
  logic [10:0] frame_r,  frame_next_s;
  logic [WD_W-1:0] wdog_r, wdog_next_s;
  logic [7:0]  dout_r,   dout_next_s;
  logic        done_r,   done_next_s;
  logic        flag_r,   flag_next_s;
  logic        err_r,    err_next_s;
  logic        brk_r,    brk_next_s;
  logic [7:0]  byte_s;
  logic        valid_s;

  ps2_filter u_filter (
    .clk       (clk),
    .reset     (reset),
    .ps2c      (ps2c),
    .ps2d      (ps2d),
    .ps2d_sync (ps2d_sync_s),
    .fall_edge (fall_edge_s)
  );

  // Next-state, frame assembly, watchdog and break-prefix decoding.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    frame_next_s = frame_r;
    wdog_next_s  = wdog_r;
    dout_next_s  = dout_r;
    done_next_s  = 1'b0;
    flag_next_s  = 1'b0;
    err_next_s   = 1'b0;
    brk_next_s   = brk_r;
    // Frame layout after 11 shifts: {stop, parity, d7..d0, start}.
    byte_s       = frame_r[8:1];
    valid_s      = odd_parity_ok(frame_r[9:1]) & frame_r[10];
    case (state_r)
      ST_IDLE: begin
        wdog_next_s = '0;
        if (fall_edge_s && rx_en && !ps2d_sync_s) begin
          frame_next_s = {ps2d_sync_s, frame_r[10:1]};
          cnt_next_s   = 4'd9;
          state_next_s = ST_DPS;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_DPS: begin
        if (fall_edge_s) begin
          frame_next_s = {ps2d_sync_s, frame_r[10:1]};
          wdog_next_s  = '0;
          if (cnt_r == 4'd0) begin
            state_next_s = ST_LOAD;
          end else begin
            cnt_next_s = cnt_r - 4'd1;
          end
        end else if (wdog_r == WD_W'(TIMEOUT_CYCLES - 1)) begin
          // Keyboard stopped clocking mid-frame: abandon it.
          state_next_s = ST_IDLE;
          wdog_next_s  = '0;
          err_next_s   = 1'b1;
          brk_next_s   = 1'b0;
        end else begin
          wdog_next_s = wdog_r + WD_W'(1);
        end
      end
      ST_LOAD: begin
        state_next_s = ST_IDLE;
        if (!valid_s) begin
          err_next_s = 1'b1;
          brk_next_s = 1'b0;
        end else if (byte_s == PS2_BRK) begin
          brk_next_s = 1'b1;
        end else if (byte_s == PS2_EXT) begin
          // E0 is reported but leaves a pending break for the code after it.
          dout_next_s = byte_s;
          done_next_s = 1'b1;
        end else begin
          dout_next_s = byte_s;
          done_next_s = 1'b1;
          flag_next_s = brk_r;
          brk_next_s  = 1'b0;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State and registered-output update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      frame_r <= 11'd0;
      wdog_r  <= '0;
      dout_r  <= 8'h00;
      done_r  <= 1'b0;
      flag_r  <= 1'b0;
      err_r   <= 1'b0;
      brk_r   <= 1'b0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      frame_r <= frame_next_s;
      wdog_r  <= wdog_next_s;
      dout_r  <= dout_next_s;
      done_r  <= done_next_s;
      flag_r  <= flag_next_s;
      err_r   <= err_next_s;
      brk_r   <= brk_next_s;
    end
  end

  assign dout         = dout_r;
  assign rx_done_tick = done_r;
  assign flag         = flag_r;
  assign err_tick     = err_r;

endmodule

// File: tb/tb_ps2_rx_flag.sv
// tb_ps2_rx_flag -- self-checking bench for ps2_rx_flag. Drives PS/2 frames
// (directed and random) and compares against a frame-level reference model.
module tb_ps2_rx_flag;

  localparam int TIMEOUT = 400;
  localparam int HALF    = 25;   // PS/2 clock half period in clk cycles

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ps2c = 1'b1;
  logic       ps2d = 1'b1;
  logic       rx_en = 1'b1;
  logic [7:0] dout;
  logic       rx_done_tick;
  logic       flag;
  logic       err_tick;

  int n_chk  = 0;
  int n_fail = 0;

  // Event counters owned by the monitor.
  int         n_done  = 0;
  int         n_err   = 0;
  int         n_stray = 0;
  logic [7:0] last_dout = 8'h00;
  logic       last_flag = 1'b0;

  // Reference model state.
  logic [7:0] dout_exp = 8'h00;
  bit         brk_exp  = 1'b0;

  ps2_rx_flag #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk          (clk),
    .reset        (reset),
    .ps2c         (ps2c),
    .ps2d         (ps2d),
    .rx_en        (rx_en),
    .dout         (dout),
    .rx_done_tick (rx_done_tick),
    .flag         (flag),
    .err_tick     (err_tick)
  );

  always #5 clk = ~clk;

  // Monitor: count output pulses away from the active edge.
  always @(negedge clk) begin
    if (rx_done_tick) begin
      n_done    <= n_done + 1;
      last_dout <= dout;
      last_flag <= flag;
    end
    if (err_tick) n_err <= n_err + 1;
    if (flag && !rx_done_tick) n_stray <= n_stray + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive the first nbits of a frame, LSB first; data changes while ps2c is high.
  task automatic send_bits(input logic [10:0] bits, input int nbits, input bit glitch,
                           input bit drop_en);
    int g;
    for (int i = 0; i < nbits; i++) begin
      ps2d = bits[i];
      wait_clks(HALF);
      ps2c = 1'b0;
      if (glitch) begin
        g = $urandom_range(3, 1);
        wait_clks(10);
        ps2c = 1'b1;
        wait_clks(g);
        ps2c = 1'b0;
        wait_clks(HALF - 10 - g);
      end else begin
        wait_clks(HALF);
      end
      ps2c = 1'b1;
      if (glitch) begin
        wait_clks(5);
        ps2c = 1'b0;
        wait_clks($urandom_range(3, 1));
        ps2c = 1'b1;
      end
      if (drop_en && i == 0) rx_en = 1'b0;
    end
    ps2d = 1'b1;
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] b, input bit bad_par);
    logic par;
    par = ~^b;
    if (bad_par) par = ~par;
    return {1'b1, par, b, 1'b0};
  endfunction

  // en_mode: 0 = enabled, 1 = disabled for whole frame, 2 = dropped after start bit.
  task automatic do_frame(input logic [7:0] b, input bit bad_par, input bit glitch,
                          input int en_mode, input string tag);
    int  d0, e0, s0;
    bit  exp_done, exp_err, exp_flag;
    d0 = n_done; e0 = n_err; s0 = n_stray;
    rx_en = (en_mode != 1);
    send_bits(make_frame(b, bad_par), 11, glitch, en_mode == 2);
    wait_clks(60);
    rx_en = 1'b1;
    exp_done = 1'b0; exp_err = 1'b0; exp_flag = 1'b0;
    if (en_mode == 1) begin
      exp_done = 1'b0;
    end else if (bad_par) begin
      exp_err = 1'b1;
      brk_exp = 1'b0;
    end else if (b == 8'hF0) begin
      brk_exp = 1'b1;
    end else if (b == 8'hE0) begin
      exp_done = 1'b1;
      dout_exp = b;
    end else begin
      exp_done = 1'b1;
      exp_flag = brk_exp;
      brk_exp  = 1'b0;
      dout_exp = b;
    end
    check_val({tag, "/done"}, n_done - d0, exp_done);
    check_val({tag, "/err"}, n_err - e0, exp_err);
    check_val({tag, "/dout"}, dout, dout_exp);
    check_val({tag, "/stray"}, n_stray - s0, 0);
    if (exp_done) check_val({tag, "/flag"}, last_flag, exp_flag);
  endtask

  initial begin
    int d0, e0, r, mode;
    logic [7:0] b;

    // Reset state.
    wait_clks(5);
    check_val("rst/dout", dout, 8'h00);
    check_val("rst/done", rx_done_tick, 1'b0);
    check_val("rst/flag", flag, 1'b0);
    check_val("rst/err", err_tick, 1'b0);
    reset = 1'b1;
    wait_clks(20);

    // Directed frames.
    do_frame(8'h1C, 1'b0, 1'b0, 0, "f1C");
    do_frame(8'hF0, 1'b0, 1'b0, 0, "brkF0");
    do_frame(8'h1A, 1'b0, 1'b0, 0, "brk1A");
    do_frame(8'h22, 1'b0, 1'b0, 0, "f22");
    do_frame(8'hF0, 1'b0, 1'b0, 0, "preF0");
    do_frame(8'h23, 1'b1, 1'b0, 0, "par23");
    do_frame(8'h21, 1'b0, 1'b0, 0, "post21");
    do_frame(8'hF0, 1'b0, 1'b0, 0, "dblF0a");
    do_frame(8'hF0, 1'b0, 1'b0, 0, "dblF0b");
    do_frame(8'hE0, 1'b0, 1'b0, 0, "extE0");
    do_frame(8'h75, 1'b0, 1'b0, 0, "ext75");
    do_frame(8'h33, 1'b0, 1'b0, 0, "after75");

    // Timeout: break pending, then a truncated frame (start + 5 data bits).
    do_frame(8'hF0, 1'b0, 1'b0, 0, "toF0");
    d0 = n_done; e0 = n_err;
    send_bits(make_frame(8'h2B, 1'b0), 6, 1'b0, 1'b0);
    wait_clks(TIMEOUT + 100);
    brk_exp = 1'b0;
    check_val("to/err", n_err - e0, 1);
    check_val("to/done", n_done - d0, 0);
    check_val("to/dout", dout, dout_exp);
    do_frame(8'h2B, 1'b0, 1'b0, 0, "to2B");

    // Glitchy PS/2 clock.
    do_frame(8'h3B, 1'b0, 1'b1, 0, "gl3B");

    // Reset in the middle of a frame with a break pending.
    do_frame(8'hF0, 1'b0, 1'b0, 0, "rstF0");
    send_bits(make_frame(8'h55, 1'b0), 7, 1'b0, 1'b0);
    reset = 1'b0;
    wait_clks(5);
    check_val("mrst/dout", dout, 8'h00);
    check_val("mrst/done", rx_done_tick, 1'b0);
    check_val("mrst/flag", flag, 1'b0);
    check_val("mrst/err", err_tick, 1'b0);
    reset = 1'b1;
    dout_exp = 8'h00;
    brk_exp  = 1'b0;
    wait_clks(20);
    do_frame(8'h2A, 1'b0, 1'b0, 0, "rst2A");

    // Random frames, including disabled / mid-frame-disabled reception.
    for (int i = 0; i < 30; i++) begin
      r = $urandom_range(7, 0);
      if (r < 2)       b = 8'hF0;
      else if (r == 2) b = 8'hE0;
      else             b = 8'($urandom);
      mode = $urandom_range(5, 0);
      if (mode > 2) mode = 0;
      do_frame(b, ($urandom_range(7, 0) == 0), ($urandom_range(3, 0) == 0), mode, "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
